// File: rtl/aclk_alarm_entry_if.sv
// Keypad-to-alarm-register bundle for the alarm entry block.
// The master drives keypad strobes; the slave (entry logic) drives the new alarm time and status.
interface aclk_alarm_entry_if;
    logic       key_valid;
    logic [3:0] key;
    logic [3:0] new_alarm_ms_hr;
    logic [3:0] new_alarm_ls_hr;
    logic [3:0] new_alarm_ms_min;
    logic [3:0] new_alarm_ls_min;
    logic       load_new_a;
    logic       entry_active;
    logic [2:0] digit_count;
    logic       err;
    logic       timeout;

    modport master (
        output key_valid, key,
        input  new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min,
        input  load_new_a, entry_active, digit_count, err, timeout
    );

    modport slave (
        input  key_valid, key,
        output new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min,
        output load_new_a, entry_active, digit_count, err, timeout
    );
endinterface

// File: rtl/aclk_alarm_entry.sv
// Keypad alarm-time entry: HH:MM shift buffer, validation, one-cycle commit, inactivity timeout.
// Optional macro AENTRY_KEY_SYNC_EN: key_valid is an async level, synchronized and edge-detected.
module aclk_alarm_entry #(
    parameter int TIMEOUT_CYCLES = 10,
    parameter int CNT_W          = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    aclk_alarm_entry_if.slave    bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_ENTRY, ST_LOAD} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [3:0][3:0]  buf_reg, buf_next, buf_shifted;
    logic [2:0]       count_reg, count_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             err_reg, err_next;
    logic             timeout_reg, timeout_next;

    logic             key_acc;
    logic [3:0]       key_in;

`ifdef AENTRY_KEY_SYNC_EN
    // Two-flop synchronizer plus rising-edge detect; key code travels in step with the strobe.
    logic       sync0_reg, sync1_reg, sync2_reg;
    logic [3:0] key0_reg, key1_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync0_reg <= 1'b0;
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            key0_reg  <= 4'd0;
            key1_reg  <= 4'd0;
        end else begin
            sync0_reg <= bus.key_valid;
            sync1_reg <= sync0_reg;
            sync2_reg <= sync1_reg;
            key0_reg  <= bus.key;
            key1_reg  <= key0_reg;
        end
    end

    assign key_acc = sync1_reg & ~sync2_reg;
    assign key_in  = key1_reg;
`else
    assign key_acc = bus.key_valid;
    assign key_in  = bus.key;
`endif

    // Left shift of the buffer: newest digit enters at index 0 (ls_min).
    assign buf_shifted[0] = key_in;
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_shift
            assign buf_shifted[gi] = buf_reg[gi-1];
        end
    endgenerate

    logic is_digit, is_alarm, is_clear, time_ok;
    assign is_digit = (key_in <= 4'd9);
    assign is_alarm = (key_in == 4'hA);
    assign is_clear = (key_in == 4'hB);
    assign time_ok  = (count_reg != 3'd0) && (buf_reg[3] <= 4'd2) &&
                      ((buf_reg[3] < 4'd2) || (buf_reg[2] <= 4'd3)) &&
                      (buf_reg[1] <= 4'd5);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            buf_reg     <= '0;
            count_reg   <= 3'd0;
            cnt_reg     <= '0;
            err_reg     <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            buf_reg     <= buf_next;
            count_reg   <= count_next;
            cnt_reg     <= cnt_next;
            err_reg     <= err_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        buf_next     = buf_reg;
        count_next   = count_reg;
        cnt_next     = cnt_reg;
        err_next     = 1'b0;
        timeout_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (key_acc && is_digit) begin
                    buf_next   = {12'h000, key_in};
                    count_next = 3'd1;
                    state_next = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (key_acc) begin
                    // Any accepted code, even an ignored one, counts as activity.
                    cnt_next = '0;
                    if (is_digit) begin
                        buf_next = buf_shifted;
                        if (count_reg < 3'd4)
                            count_next = count_reg + 3'd1;
                    end else if (is_clear) begin
                        buf_next   = '0;
                        count_next = 3'd0;
                    end else if (is_alarm) begin
                        if (time_ok) begin
                            state_next = ST_LOAD;
                        end else begin
                            err_next   = 1'b1;
                            buf_next   = '0;
                            count_next = 3'd0;
                            state_next = ST_IDLE;
                        end
                    end
                end else if (cnt_reg == CNT_LAST) begin
                    timeout_next = 1'b1;
                    buf_next     = '0;
                    count_next   = 3'd0;
                    cnt_next     = '0;
                    state_next   = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_LOAD: begin
                // Buffer is held so the outputs keep showing the committed alarm.
                count_next = 3'd0;
                cnt_next   = '0;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.new_alarm_ms_hr  = buf_reg[3];
    assign bus.new_alarm_ls_hr  = buf_reg[2];
    assign bus.new_alarm_ms_min = buf_reg[1];
    assign bus.new_alarm_ls_min = buf_reg[0];
    assign bus.load_new_a       = (state_reg == ST_LOAD);
    assign bus.entry_active     = (state_reg == ST_ENTRY);
    assign bus.digit_count      = count_reg;
    assign bus.err              = err_reg;
    assign bus.timeout          = timeout_reg;
endmodule

// File: tb/tb_aclk_alarm_entry.sv
// Self-checking bench for aclk_alarm_entry against an arithmetic model of the entry rules.
module tb_aclk_alarm_entry;
    localparam int TO = 10;

    logic clk;
    logic reset;
    aclk_alarm_entry_if bus ();

    aclk_alarm_entry #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: buffer as a 4-digit decimal number, entry modes as flags.
    int m_buf, m_count, m_idle;
    bit m_entry, m_load, m_err, m_to;

    function automatic void model_reset();
        m_buf = 0; m_count = 0; m_idle = 0;
        m_entry = 0; m_load = 0; m_err = 0; m_to = 0;
    endfunction

    function automatic void model_edge(input bit v, input int k);
        m_err = 0;
        m_to  = 0;
        if (m_load) begin
            m_load = 0;
            m_count = 0;
        end else if (!m_entry) begin
            if (v && k <= 9) begin
                m_buf = k; m_count = 1; m_entry = 1; m_idle = 0;
            end
        end else if (v) begin
            m_idle = 0;
            if (k <= 9) begin
                m_buf = (m_buf * 10 + k) % 10000;
                m_count = (m_count < 4) ? m_count + 1 : 4;
            end else if (k == 11) begin
                m_buf = 0; m_count = 0;
            end else if (k == 10) begin
                if (m_count >= 1 && m_buf / 100 <= 23 && (m_buf % 100) / 10 <= 5) begin
                    m_entry = 0; m_load = 1;
                end else begin
                    m_err = 1; m_buf = 0; m_count = 0; m_entry = 0;
                end
            end
        end else begin
            m_idle++;
            if (m_idle == TO) begin
                m_to = 1; m_buf = 0; m_count = 0; m_entry = 0; m_idle = 0;
            end
        end
    endfunction

    function automatic logic [22:0] exp_vec();
        logic [3:0] d3, d2, d1, d0;
        d3 = 4'(m_buf / 1000);
        d2 = 4'((m_buf / 100) % 10);
        d1 = 4'((m_buf / 10) % 10);
        d0 = 4'(m_buf % 10);
        return {d3, d2, d1, d0, m_load, m_entry, 3'(m_count), m_err, m_to};
    endfunction

    function automatic logic [22:0] obs_vec();
        return {bus.new_alarm_ms_hr, bus.new_alarm_ls_hr, bus.new_alarm_ms_min,
                bus.new_alarm_ls_min, bus.load_new_a, bus.entry_active,
                bus.digit_count, bus.err, bus.timeout};
    endfunction

    task automatic step(input bit v, input int k);
        @(negedge clk);
        bus.key_valid = v;
        bus.key       = 4'(k);
        @(posedge clk);
        model_edge(v, k);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.key_valid = 1'b0;
        bus.key = 4'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL reset: got %h expected %h", obs_vec(), exp_vec());
        end
        @(negedge clk);
        reset = 1'b1;
        step(0, 0);
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL reset_release: got %h expected %h", obs_vec(), exp_vec());
        end
        $display("reset: outputs %h", obs_vec());
    endtask

    // Drives a key sequence followed by three idle cycles, checking every cycle.
    task automatic test_sequence(input string name, input int ks[$]);
        int loads = 0;
        foreach (ks[i]) begin
            step(1, ks[i]);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL %s key%0d: got %h expected %h", name, i, obs_vec(), exp_vec());
            end
        end
        repeat (3) begin
            step(0, 0);
            loads += int'(bus.load_new_a);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL %s idle: got %h expected %h", name, obs_vec(), exp_vec());
            end
        end
        $display("%s: final %h%h:%h%h loads_after=%0d", name, bus.new_alarm_ms_hr,
                 bus.new_alarm_ls_hr, bus.new_alarm_ms_min, bus.new_alarm_ls_min, loads);
    endtask

    task automatic test_timeout();
        int pulses = 0;
        step(1, 1);
        step(1, 2);
        for (int i = 1; i <= TO; i++) begin
            step(0, 0);
            pulses += int'(bus.timeout);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL timeout idle%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (bus.timeout !== 1'b1 || bus.entry_active !== 1'b0 || pulses != 1) begin
            n_bad++;
            $display("FAIL timeout_pulse: got to=%b act=%b pulses=%0d expected 1 0 1",
                     bus.timeout, bus.entry_active, pulses);
        end
        step(1, 1);
        step(1, 2);
        for (int i = 1; i < TO; i++) step(0, 0);
        step(1, 3);
        n_cmp++;
        if (obs_vec() !== exp_vec() || bus.timeout !== 1'b0 || bus.entry_active !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_key_wins: got %h expected %h", obs_vec(), exp_vec());
        end
        step(1, 11);
        step(0, 0);
        $display("timeout: pulses=%0d", pulses);
    endtask

    task automatic test_reset_mid();
        step(1, 1);
        step(1, 2);
        step(1, 3);
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL midreset_pre: got %h expected %h", obs_vec(), exp_vec());
        end
        @(negedge clk);
        bus.key_valid = 1'b0;
        #2 reset = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL midreset_async: got %h expected %h", obs_vec(), exp_vec());
        end
        @(negedge clk);
        reset = 1'b1;
        step(1, 10);
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL midreset_after: got %h expected %h", obs_vec(), exp_vec());
        end
        $display("reset_mid: outputs %h", obs_vec());
    endtask

    task automatic test_random();
        int bad0 = n_bad;
        for (int i = 0; i < 600; i++) begin
            bit v;
            int k;
            if (i % 50 == 49) begin
                v = 0; k = 0;
                repeat (TO + 1) begin
                    step(0, 0);
                    n_cmp++;
                    if (obs_vec() !== exp_vec()) begin
                        n_bad++;
                        $display("FAIL random_idle %0d: got %h expected %h", i, obs_vec(), exp_vec());
                    end
                end
            end
            v = ($urandom_range(0, 2) != 0);
            k = ($urandom_range(0, 4) == 0) ? 10 : int'($urandom_range(0, 15));
            step(v, k);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random %0d v=%0d k=%0d: got %h expected %h", i, v, k, obs_vec(), exp_vec());
            end
        end
        $display("random: 600 steps, %0d new failures", n_bad - bad0);
    endtask

`ifdef AENTRY_KEY_SYNC_EN
    task automatic test_key_sync();
        int first = -1;
        int changes = 0;
        logic [2:0] last_count;
        last_count = bus.digit_count;
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key = 4'd5;
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk);
            #1;
            if (bus.digit_count !== last_count) changes++;
            last_count = bus.digit_count;
            if (first < 0 && bus.new_alarm_ls_min == 4'd5 && bus.digit_count == 3'd1) first = e;
            if (e == 6) begin
                @(negedge clk);
                bus.key_valid = 1'b0;
            end
        end
        n_cmp++;
        if (first != 3 || changes != 1 || bus.digit_count !== 3'd1) begin
            n_bad++;
            $display("FAIL key_sync: got first=%0d changes=%0d count=%0d expected 3 1 1",
                     first, changes, bus.digit_count);
        end
        $display("key_sync: first=%0d changes=%0d", first, changes);
    endtask
`endif

    initial begin
        int q[$];
        test_reset();
`ifdef AENTRY_KEY_SYNC_EN
        test_key_sync();
`else
        q = '{1, 2, 3, 4, 10};        test_sequence("commit_1234", q);
        q = '{2, 3, 5, 9, 10};        test_sequence("commit_2359", q);
        q = '{2, 4, 0, 0, 10};        test_sequence("reject_2400", q);
        q = '{7, 10};                 test_sequence("commit_0007", q);
        q = '{1, 2, 3, 4, 5, 10};     test_sequence("commit_2345", q);
        q = '{1, 2, 6, 0, 10};        test_sequence("reject_1260", q);
        q = '{10, 11, 1, 12, 15, 10, 3}; test_sequence("ignored_codes", q);
        q = '{9, 11, 10};             test_sequence("clear_then_alarm", q);
        q = '{1, 9, 5, 9, 10, 4, 10}; test_sequence("load_drops_key", q);
        test_timeout();
        test_reset_mid();
        test_random();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
